ddr3_overflow_monitor: RTL

//   Tracks DDR3 event-buffer occupancy in bursts from write/read burst strobes.

---
 rtl/ddr3_overflow_monitor.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/ddr3_overflow_monitor.sv
// DDR3 event-buffer occupancy tracker with a watermark/hold-time overflow warning and sticky error flags.
// Define DDR3_OVF_STATS_EN to build the peak-occupancy register; otherwise peak_occupancy is tied to 0.
module ddr3_overflow_monitor #(
    parameter int CNT_W    = 16,
    parameter int HIGH_WM  = 49152,
    parameter int LOW_WM   = 32768,
    parameter int HOLD_CYC = 1024,
    parameter int HOLD_W   = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             wr_burst,
    input  logic             rd_burst,
    input  logic             clear,
    output logic [CNT_W-1:0] occupancy,
    output logic             ddr3_full,
    output logic             ddr3_overflow_warning,
    output logic             overflow_err,
    output logic             underflow_err,
    output logic [CNT_W-1:0] peak_occupancy
);

    localparam logic [CNT_W-1:0]  OCC_MAX   = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0]  HIGH_LVL  = CNT_W'(HIGH_WM);
    localparam logic [CNT_W-1:0]  LOW_LVL   = CNT_W'(LOW_WM);
    localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(HOLD_CYC - 1);

    typedef enum logic [1:0] {
        ST_OK   = 2'd0,
        ST_HOLD = 2'd1,
        ST_WARN = 2'd2
    } state_e;

    logic [CNT_W-1:0]  occ_q, occ_d;
    logic              ovf_q, ovf_d;
    logic              unf_q, unf_d;
    state_e            state_q;
    logic [HOLD_W-1:0] hold_q;
    logic              warn_q;

    // Simultaneous write and read cancel out, so neither error flag can fire on that cycle.
    always_comb begin
        occ_d = occ_q;
        ovf_d = ovf_q;
        unf_d = unf_q;
        if (clear) begin
            occ_d = '0;
            ovf_d = 1'b0;
            unf_d = 1'b0;
        end else if (wr_burst && !rd_burst) begin
            if (occ_q == OCC_MAX) begin
                ovf_d = 1'b1;
            end else begin
                occ_d = occ_q + 1'b1;
            end
        end else if (rd_burst && !wr_burst) begin
            if (occ_q == '0) begin
                unf_d = 1'b1;
            end else begin
                occ_d = occ_q - 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            occ_q <= '0;
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else begin
            occ_q <= occ_d;
            ovf_q <= ovf_d;
            unf_q <= unf_d;
        end
    end

    // Warning FSM works on registered occupancy; warn_q is the decode of the state being entered.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_OK;
            hold_q  <= '0;
            warn_q  <= 1'b0;
        end else if (clear) begin
            state_q <= ST_OK;
            hold_q  <= '0;
            warn_q  <= 1'b0;
        end else begin
            case (state_q)
                ST_OK: begin
                    if (occ_q >= HIGH_LVL) begin
                        state_q <= ST_HOLD;
                        hold_q  <= HOLD_LOAD;
                        warn_q  <= 1'b1;
                    end else begin
                        warn_q  <= 1'b0;
                    end
                end
                ST_HOLD: begin
                    warn_q <= 1'b1;
                    if (hold_q == '0) begin
                        state_q <= ST_WARN;
                    end else begin
                        hold_q <= hold_q - 1'b1;
                    end
                end
                ST_WARN: begin
                    if (occ_q <= LOW_LVL) begin
                        state_q <= ST_OK;
                        warn_q  <= 1'b0;
                    end else begin
                        warn_q  <= 1'b1;
                    end
                end
                default: begin
                    state_q <= ST_OK;
                    hold_q  <= '0;
                    warn_q  <= 1'b0;
                end
            endcase
        end
    end

`ifdef DDR3_OVF_STATS_EN
    logic [CNT_W-1:0] peak_q, peak_d;

    always_comb begin
        peak_d = peak_q;
        if (clear) begin
            peak_d = '0;
        end else if (occ_q > peak_q) begin
            peak_d = occ_q;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            peak_q <= '0;
        end else begin
            peak_q <= peak_d;
        end
    end

    assign peak_occupancy = peak_q;
`else
    assign peak_occupancy = '0;
`endif

    assign occupancy             = occ_q;
    assign ddr3_full             = (occ_q == OCC_MAX);
    assign ddr3_overflow_warning = warn_q;
    assign overflow_err          = ovf_q;
    assign underflow_err         = unf_q;

endmodule
